// File: rtl/seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver
//
// Time-multiplexes a 32-bit hex word or a 64-bit ASCII word onto an 8-digit
// common-anode 7-segment panel. The panel is scanned one digit per slot of
// SCAN_DIV clock cycles, so a full frame lasts 8*SCAN_DIV cycles. All inputs
// are copied into shadow registers once per frame, at the first cycle of
// digit 0. The displayed frame therefore never mixes old and new data.
// Each slot begins with BLANK_CYCLES cycles where every anode is off. Segment
// changes happen inside that window, so they never show as ghosting on the
// neighbouring digit.
//
// Parameters
//   SCAN_DIV      clk cycles per digit slot (>= 4)
//   BLANK_CYCLES  all-anodes-off cycles at the start of each slot
//                 (1 .. SCAN_DIV-2)
//
// Ports
//   clk         in   1   system clock
//   rst         in   1   asynchronous, active-high reset
//   hex_data    in   32  hex word; digit i shows nibble [4i+3:4i]
//   ascii_data  in   64  ASCII word; digit i shows byte [8i+7:8i]
//   ascii_mode  in   1   1 = ASCII glyphs, 0 = hex glyphs
//   dp_mask     in   8   decimal point enable per digit (hex mode only)
//   an          out  8   anode enables, active-low; an[0] = rightmost digit
//   seg         out  7   segments {g,f,e,d,c,b,a}, active-low
//   dp          out  1   decimal point, active-low
//   frame_sync  out  1   one-cycle pulse following each capture cycle
// -----------------------------------------------------------------------------
module seg7_scan_driver #(
  parameter int unsigned SCAN_DIV     = 100000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] hex_data,
  input  logic [63:0] ascii_data,
  input  logic        ascii_mode,
  input  logic [7:0]  dp_mask,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_sync
);

  localparam int unsigned CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK   = CW'(BLANK_CYCLES);

  // Hex font, active-low {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex_glyph(input logic [3:0] n);
    logic [6:0] g;
    g = 7'h7F;
    case (n)
      4'h0: g = 7'h40;
      4'h1: g = 7'h79;
      4'h2: g = 7'h24;
      4'h3: g = 7'h30;
      4'h4: g = 7'h19;
      4'h5: g = 7'h12;
      4'h6: g = 7'h02;
      4'h7: g = 7'h78;
      4'h8: g = 7'h00;
      4'h9: g = 7'h10;
      4'hA: g = 7'h08;
      4'hB: g = 7'h03;
      4'hC: g = 7'h46;
      4'hD: g = 7'h21;
      4'hE: g = 7'h06;
      4'hF: g = 7'h0E;
      default: g = 7'h7F;
    endcase
    return g;
  endfunction

  // ASCII font. Lowercase letters are folded onto uppercase first. Any code
  // without a glyph shows as a blank digit.
  function automatic logic [6:0] ascii_glyph(input logic [7:0] c);
    logic [7:0] u;
    logic [6:0] g;
    u = ((c >= 8'h61) && (c <= 8'h7A)) ? (c - 8'h20) : c;
    g = 7'h7F;
    case (u) inside
      [8'h30:8'h39]: g = hex_glyph(u[3:0]);          // '0'..'9'
      [8'h41:8'h46]: g = hex_glyph(u[3:0] + 4'd9);   // 'A'..'F'
      8'h48:         g = 7'h09;                      // H
      8'h4C:         g = 7'h47;                      // L
      8'h4F:         g = 7'h40;                      // O
      8'h50:         g = 7'h0C;                      // P
      8'h55:         g = 7'h41;                      // U
      8'h4E:         g = 7'h2B;                      // N
      8'h52:         g = 7'h2F;                      // R
      8'h54:         g = 7'h07;                      // T
      8'h59:         g = 7'h11;                      // Y
      8'h20:         g = 7'h7F;                      // space
      8'h2D:         g = 7'h3F;                      // '-'
      8'h5F:         g = 7'h77;                      // '_'
      default:       g = 7'h7F;
    endcase
    return g;
  endfunction

  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [31:0]   hex_shadow;
  logic [63:0]   ascii_shadow;
  logic          mode_shadow;
  logic [7:0]    dp_shadow;

  logic        capture;
  logic [31:0] cur_hex;
  logic [63:0] cur_ascii;
  logic        cur_mode;
  logic [7:0]  cur_dp;
  logic [3:0]  nibble;
  logic [7:0]  ch;
  logic [7:0]  an_next;
  logic [6:0]  seg_next;
  logic        dp_next;

  assign capture = (cnt == '0) && (idx == 3'd0);

  // On the capture cycle the decode reads the incoming words directly.
  // Digit 0 then shows the new frame from its first, still-blanked cycle, so
  // the segment change never coincides with the anode turning on.
  always_comb begin
    // NOTE: every always_comb output gets a default first; a path that leaves a
    // variable unassigned would infer a latch.
    cur_hex   = hex_shadow;
    cur_ascii = ascii_shadow;
    cur_mode  = mode_shadow;
    cur_dp    = dp_shadow;
    if (capture) begin
      cur_hex   = hex_data;
      cur_ascii = ascii_data;
      cur_mode  = ascii_mode;
      cur_dp    = dp_mask;
    end

    nibble   = cur_hex[{idx, 2'b00} +: 4];
    ch       = cur_ascii[{idx, 3'b000} +: 8];
    seg_next = cur_mode ? ascii_glyph(ch) : hex_glyph(nibble);
    dp_next  = cur_mode | ~cur_dp[idx];

    an_next = 8'hFF;
    if (cnt >= BLANK) an_next[idx] = 1'b0;
  end

  // Scan position and the per-frame shadow copy of the inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt          <= '0;
      idx          <= 3'd0;
      // NOTE: the shadow registers are few flops rather than a memory array,
      // so they are reset like the rest of the state.
      hex_shadow   <= '0;
      ascii_shadow <= '0;
      mode_shadow  <= 1'b0;
      dp_shadow    <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so that every
      // flop samples its inputs from before the clock edge.
      if (cnt == CNT_MAX) begin
        cnt <= '0;
        idx <= idx + 3'd1;
      end else begin
        cnt <= cnt + 1'b1;
      end

      if (capture) begin
        hex_shadow   <= hex_data;
        ascii_shadow <= ascii_data;
        mode_shadow  <= ascii_mode;
        dp_shadow    <= dp_mask;
      end
    end
  end

  // Registered pin drivers. They reflect the scan position one cycle late.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an         <= 8'hFF;
      seg        <= 7'h7F;
      dp         <= 1'b1;
      frame_sync <= 1'b0;
    end else begin
      an         <= an_next;
      seg        <= seg_next;
      dp         <= dp_next;
      frame_sync <= capture;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
module tb_seg7_scan_driver;

  localparam int SCAN_DIV     = 8;
  localparam int BLANK_CYCLES = 2;
  localparam int FRAME        = 8 * SCAN_DIV;

  logic        clk;
  logic        rst;
  logic [31:0] hex_data;
  logic [63:0] ascii_data;
  logic        ascii_mode;
  logic [7:0]  dp_mask;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_sync;

  int n_checks = 0;
  int n_errors = 0;

  seg7_scan_driver #(
    .SCAN_DIV    (SCAN_DIV),
    .BLANK_CYCLES(BLANK_CYCLES)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .hex_data  (hex_data),
    .ascii_data(ascii_data),
    .ascii_mode(ascii_mode),
    .dp_mask   (dp_mask),
    .an        (an),
    .seg       (seg),
    .dp        (dp),
    .frame_sync(frame_sync)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: glyph tables and a frame/time view of the scan.
  // ---------------------------------------------------------------------------
  logic [6:0] hex_font [16];
  logic [6:0] ascii_font [256];

  initial begin
    hex_font = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    for (int i = 0; i < 256; i++) ascii_font[i] = 7'h7F;
    for (int i = 0; i < 10; i++) ascii_font[8'h30 + i] = hex_font[i];
    for (int i = 0; i < 6; i++) ascii_font[8'h41 + i] = hex_font[10 + i];
    ascii_font[8'h48] = 7'h09;  // H
    ascii_font[8'h4C] = 7'h47;  // L
    ascii_font[8'h4F] = 7'h40;  // O
    ascii_font[8'h50] = 7'h0C;  // P
    ascii_font[8'h55] = 7'h41;  // U
    ascii_font[8'h4E] = 7'h2B;  // N
    ascii_font[8'h52] = 7'h2F;  // R
    ascii_font[8'h54] = 7'h07;  // T
    ascii_font[8'h59] = 7'h11;  // Y
    ascii_font[8'h2D] = 7'h3F;  // '-'
    ascii_font[8'h5F] = 7'h77;  // '_'
    for (int i = 0; i < 26; i++) ascii_font[8'h61 + i] = ascii_font[8'h41 + i];
  end

  // t = clock edges since reset release. The outputs after edge t+1 show
  // position t mod FRAME. The frame in view was latched at the edge where
  // that position was 0.
  int unsigned t;
  logic [31:0] f_hex;
  logic [63:0] f_ascii;
  logic        f_mode;
  logic [7:0]  f_dp;
  logic [7:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_dp;
  logic        e_fs;

  always @(posedge clk) begin
    if (rst) begin
      t     = 0;
      e_an  = 8'hFF;
      e_seg = 7'h7F;
      e_dp  = 1'b1;
      e_fs  = 1'b0;
    end else begin
      int q;
      int d;
      int s;
      q = t % FRAME;
      d = q / SCAN_DIV;
      s = q % SCAN_DIV;
      if (q == 0) begin
        f_hex   = hex_data;
        f_ascii = ascii_data;
        f_mode  = ascii_mode;
        f_dp    = dp_mask;
      end
      e_fs  = (q == 0);
      e_an  = (s >= BLANK_CYCLES) ? ~(8'd1 << d) : 8'hFF;
      e_seg = f_mode ? ascii_font[f_ascii[8*d +: 8]] : hex_font[f_hex[4*d +: 4]];
      e_dp  = f_mode ? 1'b1 : ~f_dp[d];
      t++;
    end
  end

  // Compare process: every falling edge, DUT against the model.
  int cyc = 0;
  int last_fs = -1;
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      last_fs = -1;
      check("an_in_reset",  64'(an),  64'hFF);
      check("seg_in_reset", 64'(seg), 64'h7F);
      check("dp_in_reset",  64'(dp),  64'h1);
      check("fs_in_reset",  64'(frame_sync), 64'h0);
    end else begin
      check("an",  64'(an),  64'(e_an));
      check("seg", 64'(seg), 64'(e_seg));
      check("dp",  64'(dp),  64'(e_dp));
      check("frame_sync", 64'(frame_sync), 64'(e_fs));
      check("an_single_low", 64'($countones(~an) <= 1), 64'h1);
      if (frame_sync === 1'b1) begin
        if (last_fs >= 0) check("fs_period", 64'(cyc - last_fs), 64'(FRAME));
        last_fs = cyc;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic wait_an(input logic [7:0] v);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (an !== v && n < 4 * FRAME);
    if (an !== v) check("wait_an_timeout", 64'(an), 64'(v));
  endtask

  task automatic wait_fs();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_sync !== 1'b1 && n < 4 * FRAME);
    if (frame_sync !== 1'b1) check("wait_fs_timeout", 64'(frame_sync), 64'h1);
  endtask

  function automatic logic [63:0] rand_ascii();
    string pool;
    logic [63:0] w;
    pool = " -_0123456789AaBbCcDdEeFfHhLlOoPpUuNnRrTtYy~gGzZ";
    for (int i = 0; i < 8; i++) begin
      if ($urandom_range(0, 3) == 0) w[8*i +: 8] = 8'($urandom);
      else w[8*i +: 8] = 8'(pool[int'($urandom_range(0, pool.len() - 1))]);
    end
    return w;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Directed scenarios, then a randomized run
  // ---------------------------------------------------------------------------
  initial begin
    rst        = 1'b1;
    hex_data   = 32'hDEAD_BEEF;
    ascii_data = 64'h0;
    ascii_mode = 1'b0;
    dp_mask    = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    wait_an(8'hFE);

    // Reset asserted in the middle of a lit slot blanks the pins at once.
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midslot_rst_an",  64'(an),  64'hFF);
    check("midslot_rst_seg", 64'(seg), 64'h7F);
    check("midslot_rst_dp",  64'(dp),  64'h1);
    check("midslot_rst_fs",  64'(frame_sync), 64'h0);
    hex_data = 32'h0123_ABCD;
    dp_mask  = 8'h01;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Restart timing: capture at the first edge, then two blank cycles,
    // six lit cycles on digit 0, and blank again.
    @(posedge clk); #1;
    check("restart_fs_1", 64'(frame_sync), 64'h1);
    check("restart_an_1", 64'(an), 64'hFF);
    @(posedge clk); #1;
    check("restart_fs_2", 64'(frame_sync), 64'h0);
    check("restart_an_2", 64'(an), 64'hFF);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      check("restart_an_lit", 64'(an), 64'hFE);
      if (k == 0) begin
        check("hex_d0_seg", 64'(seg), 64'h21);
        check("hex_d0_dp",  64'(dp),  64'h0);
      end
    end
    @(posedge clk); #1;
    check("restart_an_next_blank", 64'(an), 64'hFF);

    wait_an(8'hF7);
    check("hex_d3_seg", 64'(seg), 64'h08);
    wait_an(8'h7F);
    check("hex_d7_seg", 64'(seg), 64'h40);
    check("hex_d7_dp",  64'(dp),  64'h1);

    // ASCII "HELLO 12".
    ascii_mode = 1'b1;
    ascii_data = "HELLO 12";
    wait_fs();
    wait_an(8'hFE);
    check("ascii_d0_seg", 64'(seg), 64'h24);
    check("ascii_d0_dp",  64'(dp),  64'h1);
    wait_an(8'hFB);
    check("ascii_d2_seg", 64'(seg), 64'h7F);
    wait_an(8'hBF);
    check("ascii_d6_seg", 64'(seg), 64'h06);
    wait_an(8'h7F);
    check("ascii_d7_seg", 64'(seg), 64'h09);
    check("ascii_d7_dp",  64'(dp),  64'h1);

    // Data changed mid-frame stays invisible until the next capture.
    ascii_mode = 1'b0;
    hex_data   = 32'h1111_1111;
    dp_mask    = 8'h00;
    wait_fs();
    wait_an(8'hF7);
    hex_data = 32'h2222_2222;
    wait_an(8'hEF);
    check("tear_d4_seg", 64'(seg), 64'h79);
    wait_an(8'h7F);
    check("tear_d7_seg", 64'(seg), 64'h79);
    wait_fs();
    wait_an(8'hFE);
    check("tear_new_d0_seg", 64'(seg), 64'h24);

    // Unmapped and lowercase ASCII codes.
    ascii_mode = 1'b1;
    ascii_data = {8'h5A, 8'h5F, 8'h2D, 8'h79, 8'h74, "r", "h", 8'h7E};
    wait_fs();
    wait_an(8'hFE);
    check("ascii_tilde_seg", 64'(seg), 64'h7F);
    wait_an(8'hFD);
    check("ascii_lower_h_seg", 64'(seg), 64'h09);
    wait_an(8'hFB);
    check("ascii_lower_r_seg", 64'(seg), 64'h2F);

    // Randomized run, including one asynchronous reset mid-frame.
    for (int it = 0; it < 24; it++) begin
      repeat ($urandom_range(1, 80)) @(negedge clk);
      hex_data   = $urandom;
      ascii_data = rand_ascii();
      ascii_mode = 1'($urandom_range(0, 1));
      dp_mask    = 8'($urandom);
      if (it == 12) begin
        @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
      end
    end
    repeat (2 * FRAME) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
